dram_responder_model: RTL

//  Responder end of the simplified memory interface (MemReq/MemResp): consumes requests an initiator drives

---
 rtl/dram_responder_model.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dram_responder_model.sv
// dram_responder_model: responder end of the MemReq/MemResp channel.
// Stores 64B lines on chip and returns read data in grant order after a
// fixed latency. The number of outstanding reads is bounded by a credit count.
// Port packing: mem_req_in = {valid, isWrite, addr[63:0], data[511:0]},
//               mem_resp_out = {valid, data[511:0]}.
module dram_responder_model #(
  parameter int LOG_LINES      = 10,
  parameter int READ_LATENCY   = 4,
  parameter int LOG_RESP_DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [577:0] mem_req_in,
  output logic         mem_req_grant_out,
  output logic [512:0] mem_resp_out,
  input  logic         mem_resp_grant_in,
  input  logic         stall_in,
  output logic [31:0]  read_count_out,
  output logic [31:0]  write_count_out
);

  localparam int unsigned LINES  = 1 << LOG_LINES;
  localparam int unsigned DEPTH  = 1 << LOG_RESP_DEPTH;
  localparam int unsigned STAGES = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
  localparam logic [LOG_RESP_DEPTH:0]   CNT_ONE = (LOG_RESP_DEPTH + 1)'(1);
  localparam logic [LOG_RESP_DEPTH-1:0] PTR_ONE = LOG_RESP_DEPTH'(1);

  logic         req_valid;
  logic         req_write;
  logic [63:0]  req_addr;
  logic [511:0] req_data;
  logic [LOG_LINES-1:0] line_idx;
  logic         unused_addr_bits;

  assign req_valid = mem_req_in[577];
  assign req_write = mem_req_in[576];
  assign req_addr  = mem_req_in[575:512];
  assign req_data  = mem_req_in[511:0];
  assign line_idx  = req_addr[LOG_LINES+5:6];
  // Offset-within-line and high address bits are ignored; addresses alias.
  assign unused_addr_bits = ^{req_addr[63:LOG_LINES+6], req_addr[5:0]};

  logic [511:0] lines [LINES];
  logic [511:0] rd_line;
  assign rd_line = lines[line_idx];

  logic [LOG_RESP_DEPTH:0]   outstanding;
  logic [LOG_RESP_DEPTH:0]   fifo_count;
  logic [LOG_RESP_DEPTH-1:0] rd_ptr;
  logic [LOG_RESP_DEPTH-1:0] wr_ptr;
  logic [511:0]              fifo_mem [DEPTH];

  logic fifo_nonempty;
  logic resp_pop;
  logic credit_ok;
  logic grant;
  logic rd_grant;
  logic wr_grant;
  logic push_v;
  logic [511:0] push_d;

  assign fifo_nonempty = (fifo_count != '0);
  assign resp_pop      = fifo_nonempty && mem_resp_grant_in;
  // outstanding never exceeds DEPTH, so its top bit clear means below DEPTH.
  // A pop this cycle frees a credit that a read may use in the same cycle.
  assign credit_ok     = !outstanding[LOG_RESP_DEPTH] || resp_pop;
  assign grant         = !rst && req_valid && !stall_in && (req_write || credit_ok);
  assign rd_grant      = grant && !req_write;
  assign wr_grant      = grant && req_write;

  assign mem_req_grant_out = grant;
  assign mem_resp_out      = {fifo_nonempty, fifo_nonempty ? fifo_mem[rd_ptr] : 512'b0};

  // Line array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_grant) lines[line_idx] <= req_data;
  end

  // Read latency shift pipeline; the last stage feeds the response FIFO so a
  // read granted in cycle T is visible at the FIFO head in cycle T+READ_LATENCY.
  generate
    if (READ_LATENCY == 1) begin : g_no_pipe
      assign push_v = rd_grant;
      assign push_d = rd_line;
    end else begin : g_pipe
      logic         pipe_v [STAGES];
      logic [511:0] pipe_d [STAGES];

      // Valid bits are cleared by reset so in-flight reads are dropped.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < STAGES; i++) pipe_v[i] <= 1'b0;
        end else begin
          pipe_v[0] <= rd_grant;
          for (int unsigned i = 1; i < STAGES; i++) pipe_v[i] <= pipe_v[i-1];
        end
      end

      // Data stages shift unconditionally.
      always_ff @(posedge clk) begin
        pipe_d[0] <= rd_line;
        for (int unsigned i = 1; i < STAGES; i++) pipe_d[i] <= pipe_d[i-1];
      end

      assign push_v = pipe_v[STAGES-1];
      assign push_d = pipe_d[STAGES-1];
    end
  endgenerate

  // Response FIFO storage.
  always_ff @(posedge clk) begin
    if (push_v) fifo_mem[wr_ptr] <= push_d;
  end

  // FIFO pointers, occupancy and outstanding-read credit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else begin
      if (push_v)   wr_ptr <= wr_ptr + PTR_ONE;
      if (resp_pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push_v && !resp_pop)      fifo_count <= fifo_count + CNT_ONE;
      else if (!push_v && resp_pop) fifo_count <= fifo_count - CNT_ONE;
      if (rd_grant && !resp_pop)      outstanding <= outstanding + CNT_ONE;
      else if (!rd_grant && resp_pop) outstanding <= outstanding - CNT_ONE;
    end
  end

  // Granted request counters, wrapping at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_count_out  <= '0;
      write_count_out <= '0;
    end else begin
      if (rd_grant) read_count_out  <= read_count_out + 32'd1;
      if (wr_grant) write_count_out <= write_count_out + 32'd1;
    end
  end

endmodule
